// File: rtl/axil_master_fsm_if.sv
// AXI-Lite bus bundle between the command-driven master and a single slave.
interface axil_master_fsm_if;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic        BVALID;
    logic [1:0]  BRESP;
    logic        BREADY;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] ARADDR;
    logic        RVALID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RREADY;

    modport master (
        output AWVALID, AWADDR, input AWREADY,
        output WVALID, WDATA, input WREADY,
        input  BVALID, BRESP, output BREADY,
        output ARVALID, ARADDR, input ARREADY,
        input  RVALID, RDATA, RRESP, output RREADY
    );

    modport slave (
        input  AWVALID, AWADDR, output AWREADY,
        input  WVALID, WDATA, output WREADY,
        output BVALID, BRESP, input BREADY,
        input  ARVALID, ARADDR, output ARREADY,
        output RVALID, RDATA, RRESP, input RREADY
    );
endinterface

// File: rtl/axil_master_fsm.sv
// Single-outstanding AXI-Lite master: turns one command into one AXI read or
// write transaction and returns a response, aborting any channel wait that
// lasts TIMEOUT cycles.
module axil_master_fsm #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [31:0]       cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    axil_master_fsm_if.master axi
);
    // One spare bit so the counter never wraps while sitting in DONE.
    localparam int unsigned     CntW    = $clog2(TIMEOUT) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StWrite, StWresp, StRead, StRdata, StDone} state_e;

    state_e          state_q, state_d;
    logic [31:0]     addr_q, wdata_q, rdata_q;
    logic [1:0]      resp_q;
    logic            timeout_q;
    logic            aw_done_q, w_done_q;
    logic [CntW-1:0] cnt_q;

    logic aw_vld, w_vld, ar_vld, b_rdy, r_rdy;
    logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
    logic waiting, expire;

    // VALID/READY are pure functions of registered state, never of the peer READY/VALID.
    assign aw_vld  = (state_q == StWrite) && !aw_done_q;
    assign w_vld   = (state_q == StWrite) && !w_done_q;
    assign ar_vld  = (state_q == StRead);
    assign b_rdy   = (state_q == StWresp);
    assign r_rdy   = (state_q == StRdata);

    assign cmd_hs  = cmd_valid && (state_q == StIdle);
    assign aw_hs   = aw_vld && axi.AWREADY;
    assign w_hs    = w_vld && axi.WREADY;
    assign b_hs    = b_rdy && axi.BVALID;
    assign ar_hs   = ar_vld && axi.ARREADY;
    assign r_hs    = r_rdy && axi.RVALID;
    assign any_hs  = aw_hs | w_hs | b_hs | ar_hs | r_hs;

    assign waiting = (state_q == StWrite) || (state_q == StWresp) ||
                     (state_q == StRead)  || (state_q == StRdata);
    // A handshake in the last allowed cycle takes priority over the abort.
    assign expire  = waiting && !any_hs && (cnt_q == CntLast);

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) state_d = cmd_write ? StWrite : StRead;
            end
            StWrite: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StWresp;
                else if (expire)                                 state_d = StDone;
            end
            StWresp: begin
                if (b_hs || expire) state_d = StDone;
            end
            StRead: begin
                if (ar_hs)       state_d = StRdata;
                else if (expire) state_d = StDone;
            end
            StRdata: begin
                if (r_hs || expire) state_d = StDone;
            end
            StDone: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Command latch, per-channel done flags, timeout counter and response capture.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            resp_q    <= 2'b00;
            timeout_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
        end else if (cmd_hs) begin
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_write ? cmd_wdata : 32'h0;
            rdata_q   <= 32'h0;
            resp_q    <= 2'b00;
            timeout_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if (any_hs) begin
                cnt_q <= '0;
            end else if (waiting) begin
                cnt_q <= cnt_q + CntW'(1);
            end
            if (b_hs) resp_q <= axi.BRESP;
            if (r_hs) begin
                rdata_q <= axi.RDATA;
                resp_q  <= axi.RRESP;
            end
            if (expire) begin
                rdata_q   <= 32'h0;
                resp_q    <= 2'b10;
                timeout_q <= 1'b1;
            end
        end
    end

    // Output drive.
    always_comb begin
        cmd_ready   = (state_q == StIdle);
        rsp_valid   = (state_q == StDone);
        rsp_rdata   = rdata_q;
        rsp_resp    = resp_q;
        rsp_timeout = timeout_q;
        axi.AWVALID = aw_vld;
        axi.AWADDR  = addr_q;
        axi.WVALID  = w_vld;
        axi.WDATA   = wdata_q;
        axi.BREADY  = b_rdy;
        axi.ARVALID = ar_vld;
        axi.ARADDR  = addr_q;
        axi.RREADY  = r_rdy;
    end
endmodule
